// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
// Shares one ibex-protocol memory port between the instruction-fetch host and
// the data host. The selection is held from request to grant. An in-order ID
// FIFO records which host owns each outstanding transaction, and responses are
// routed back to that host.
//
// Optional build macro: IBEX_MEM_ARB_PERF_EN adds saturating conflict/stall
// performance counters (perf_conflict_o, perf_stall_o).

module ibex_mem_arbiter #(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          RoundRobin     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
`ifdef IBEX_MEM_ARB_PERF_EN
   output logic [31:0] perf_conflict_o,
   output logic [31:0] perf_stall_o,
`endif
   output logic        unexp_rsp_o
);

   localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

   typedef enum logic [0:0] {
      StIdle   = 1'b0,
      StLocked = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic                      lock_data_q, lock_data_d;   // locked host, 1 = data
   logic                      rr_data_q, rr_data_d;       // round-robin favours data when 1
   logic [MaxOutstanding-1:0] id_fifo_q, id_fifo_d;       // per-entry owner, 1 = data
   logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]           count_q, count_d;
   logic                      unexp_q, unexp_d;

   logic sel_data;
   logic sel_req;
   logic not_full;
   logic fifo_empty;
   logic handshake;
   logic rsp_valid;
   logic head_data;

   // Host selection: the lock wins, otherwise the sole requester or the arbitration winner.
   always_comb begin
      sel_data = 1'b0;
      if (state_q == StLocked) begin
         sel_data = lock_data_q;
      end else if (instr_req_i && data_req_i) begin
         sel_data = RoundRobin ? rr_data_q : 1'b1;
      end else if (data_req_i) begin
         sel_data = 1'b1;
      end else begin
         sel_data = 1'b0;
      end
   end

   // The full check uses the registered count, so a same-cycle pop cannot unblock a request.
   assign sel_req    = sel_data ? data_req_i : instr_req_i;
   assign not_full   = (count_q < CntMax);
   assign fifo_empty = (count_q == {CntW{1'b0}});
   assign mem_req_o  = ~rst_i & sel_req & not_full;
   assign handshake  = mem_req_o & mem_gnt_i;

   assign instr_gnt_o = handshake & ~sel_data;
   assign data_gnt_o  = handshake & sel_data;

   // Responses go to the host that owns the FIFO head. A response with nothing outstanding is dropped.
   assign head_data      = id_fifo_q[rd_ptr_q];
   assign rsp_valid      = mem_rvalid_i & ~fifo_empty;
   assign instr_rvalid_o = rsp_valid & ~head_data;
   assign data_rvalid_o  = rsp_valid & head_data;
   assign instr_err_o    = instr_rvalid_o & mem_err_i;
   assign data_err_o     = data_rvalid_o & mem_err_i;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign unexp_rsp_o    = unexp_q;

   // Request mux: fetches are always full-word reads.
   always_comb begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_wdata_o = 32'h0000_0000;
      if (sel_data) begin
         mem_addr_o  = data_addr_i;
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_wdata_o = data_wdata_i;
      end else begin
         mem_addr_o  = instr_addr_i;
         mem_we_o    = 1'b0;
         mem_be_o    = 4'hF;
         mem_wdata_o = 32'h0000_0000;
      end
   end

   // FSM next state: lock onto a stalled request and release the lock on its handshake.
   always_comb begin
      state_d     = state_q;
      lock_data_d = lock_data_q;
      rr_data_d   = rr_data_q;
      case (state_q)
         StIdle: begin
            if (mem_req_o && !mem_gnt_i) begin
               state_d     = StLocked;
               lock_data_d = sel_data;
            end else begin
               state_d = StIdle;
            end
         end
         StLocked: begin
            if (handshake) begin
               state_d = StIdle;
            end else begin
               state_d = StLocked;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (handshake && RoundRobin) begin
         rr_data_d = ~sel_data;
      end else begin
         rr_data_d = rr_data_q;
      end
   end

   // ID FIFO bookkeeping: push the owner on a handshake and pop on a valid response.
   always_comb begin
      id_fifo_d = id_fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      unexp_d   = unexp_q;
      if (handshake) begin
         id_fifo_d[wr_ptr_q] = sel_data;
         wr_ptr_d = (wr_ptr_q == PtrLast) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rsp_valid) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({handshake, rsp_valid})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (mem_rvalid_i && fifo_empty) begin
         unexp_d = 1'b1;
      end else begin
         unexp_d = unexp_q;
      end
   end

   // State registers. Reset empties the FIFO, unlocks, and favours data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         lock_data_q <= 1'b0;
         rr_data_q   <= 1'b1;
         id_fifo_q   <= {MaxOutstanding{1'b0}};
         wr_ptr_q    <= {PtrW{1'b0}};
         rd_ptr_q    <= {PtrW{1'b0}};
         count_q     <= {CntW{1'b0}};
         unexp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_data_q <= lock_data_d;
         rr_data_q   <= rr_data_d;
         id_fifo_q   <= id_fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         unexp_q     <= unexp_d;
      end
   end

`ifdef IBEX_MEM_ARB_PERF_EN
   logic [31:0] perf_conflict_q;
   logic [31:0] perf_stall_q;

   // Saturating counters for host conflicts and device stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_conflict_q <= 32'h0000_0000;
         perf_stall_q    <= 32'h0000_0000;
      end else begin
         if (instr_req_i && data_req_i && (perf_conflict_q != 32'hFFFF_FFFF)) begin
            perf_conflict_q <= perf_conflict_q + 32'd1;
         end
         if (mem_req_o && !mem_gnt_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_conflict_o = perf_conflict_q;
   assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter. It applies a per-cycle vector table
// and then hand-written lock and reset sequences. A host-ID queue serves as the
// scoreboard: an entry is pushed on each expected grant and popped when the
// device returns a response.

module tb_ibex_mem_arbiter;

   localparam logic [31:0] IAddr = 32'h0000_0100;
   localparam logic [31:0] DAddr = 32'h0000_2000;
   localparam logic [31:0] DWdat = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_gnt, data_rvalid, data_we, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        unexp_rsp;
`ifdef IBEX_MEM_ARB_PERF_EN
   logic [31:0] perf_conflict, perf_stall;
`endif

   always #5 clk = ~clk;

   ibex_mem_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b1)) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
      .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
      .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
      .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
`ifdef IBEX_MEM_ARB_PERF_EN
      .perf_conflict_o(perf_conflict), .perf_stall_o(perf_stall),
`endif
      .unexp_rsp_o(unexp_rsp)
   );

   typedef struct {
      logic        ir, dr, dwe;
      logic [3:0]  dbe;
      logic        gnt, rv, err;
      logic [31:0] rdata;
      logic        e_mreq, e_igt, e_dgt;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   logic sb_q[$];          // expected owner of each outstanding transaction, 1 = data
   logic exp_unexp = 1'b0;
   vec_t tbl[18];

   function automatic vec_t mkv(logic ir, logic dr, logic dwe, logic [3:0] dbe, logic gnt,
                                logic rv, logic err, logic [31:0] rdata,
                                logic e_mreq, logic e_igt, logic e_dgt);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.gnt = gnt;
      v.rv = rv; v.err = err; v.rdata = rdata;
      v.e_mreq = e_mreq; v.e_igt = e_igt; v.e_dgt = e_dgt;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle, check the combinational outputs mid-cycle, update the scoreboard, and advance.
   task automatic run_cycle(vec_t v, string tag);
      logic h, e_irv, e_drv;
      instr_req = v.ir; data_req = v.dr; data_we = v.dwe; data_be = v.dbe;
      mem_gnt = v.gnt; mem_rvalid = v.rv; mem_err = v.err; mem_rdata = v.rdata;
      #2;
      chk({tag, " mem_req"}, {31'd0, mem_req}, {31'd0, v.e_mreq});
      chk({tag, " instr_gnt"}, {31'd0, instr_gnt}, {31'd0, v.e_igt});
      chk({tag, " data_gnt"}, {31'd0, data_gnt}, {31'd0, v.e_dgt});
      chk({tag, " unexp"}, {31'd0, unexp_rsp}, {31'd0, exp_unexp});
      if (v.e_igt) begin
         chk({tag, " addr_i"}, mem_addr, IAddr);
         chk({tag, " we_i"}, {31'd0, mem_we}, 32'd0);
         chk({tag, " be_i"}, {28'd0, mem_be}, 32'h0000_000F);
         chk({tag, " wdata_i"}, mem_wdata, 32'd0);
      end
      if (v.e_dgt) begin
         chk({tag, " addr_d"}, mem_addr, DAddr);
         chk({tag, " we_d"}, {31'd0, mem_we}, {31'd0, v.dwe});
         chk({tag, " be_d"}, {28'd0, mem_be}, {28'd0, v.dbe});
         chk({tag, " wdata_d"}, mem_wdata, DWdat);
      end
      e_irv = 1'b0; e_drv = 1'b0;
      if (v.rv && sb_q.size() > 0) begin
         h = sb_q.pop_front();
         e_irv = ~h; e_drv = h;
      end else if (v.rv) begin
         exp_unexp = 1'b1;
      end
      chk({tag, " instr_rvalid"}, {31'd0, instr_rvalid}, {31'd0, e_irv});
      chk({tag, " data_rvalid"}, {31'd0, data_rvalid}, {31'd0, e_drv});
      chk({tag, " instr_err"}, {31'd0, instr_err}, {31'd0, e_irv & v.err});
      chk({tag, " data_err"}, {31'd0, data_err}, {31'd0, e_drv & v.err});
      if (e_irv) chk({tag, " instr_rdata"}, instr_rdata, v.rdata);
      if (e_drv) chk({tag, " data_rdata"}, data_rdata, v.rdata);
      if (v.e_igt) sb_q.push_back(1'b0);
      if (v.e_dgt) sb_q.push_back(1'b1);
      @(posedge clk);
      #1;
   endtask

   // Assert reset while both hosts request. Requests, grants and flags must all read zero.
   task automatic apply_reset();
      rst = 1'b1; instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
      mem_rvalid = 1'b0; mem_err = 1'b0;
      #2;
      chk("rst mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst instr_gnt", {31'd0, instr_gnt}, 32'd0);
      chk("rst data_gnt", {31'd0, data_gnt}, 32'd0);
      chk("rst rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      chk("rst unexp", {31'd0, unexp_rsp}, 32'd0);
      sb_q.delete();
      exp_unexp = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      instr_addr = IAddr; data_addr = DAddr; data_wdata = DWdat;
      instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'd0;

      //             ir    dr    we    be    gnt   rv    err   rdata          mreq  igt   dgt
      // Round-robin: both hosts request continuously, with a response one cycle later.
      tbl[0]  = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
      tbl[1]  = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 32'hA1,       1'b1, 1'b1, 1'b0);
      tbl[2]  = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 32'hA2,       1'b1, 1'b0, 1'b1);
      tbl[3]  = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 32'hA3,       1'b1, 1'b1, 1'b0);
      tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hA4,       1'b0, 1'b0, 1'b0);
      // Single fetch.
      tbl[5]  = mkv(1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);
      tbl[6]  = mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h13,       1'b0, 1'b0, 1'b0);
      // Data store that receives an error response.
      tbl[7]  = mkv(1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
      tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0);
      // Full FIFO: a same-cycle pop does not unblock the request.
      tbl[9]  = mkv(1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);
      tbl[10] = mkv(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
      tbl[11] = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
      tbl[12] = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 32'hB1,       1'b0, 1'b0, 1'b0);
      tbl[13] = mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);
      tbl[14] = mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hB2,       1'b0, 1'b0, 1'b0);
      tbl[15] = mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hB3,       1'b0, 1'b0, 1'b0);
      // Leave the round-robin pointer favouring instr before the lock sequence.
      tbl[16] = mkv(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
      tbl[17] = mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hC1,       1'b0, 1'b0, 1'b0);

      apply_reset();
      for (int i = 0; i < 18; i++) begin
         run_cycle(tbl[i], $sformatf("vec%0d", i));
      end

      // Lock: a stalled data request keeps the port even though instr is favoured.
      run_cycle(mkv(1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0), "lock0");
      run_cycle(mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0), "lock1");
      chk("lock1 addr", mem_addr, DAddr);
      run_cycle(mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0), "lock2");
      run_cycle(mkv(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1), "lock3");
      run_cycle(mkv(1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0), "lock4");
      run_cycle(mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hD1, 1'b0, 1'b0, 1'b0), "lock5");
      run_cycle(mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hD2, 1'b0, 1'b0, 1'b0), "lock6");
`ifdef IBEX_MEM_ARB_PERF_EN
      chk("perf_stall", perf_stall, 32'd3);
      chk("perf_conflict", perf_conflict, 32'd10);
`endif

      // Reset mid-operation: the response to the orphaned fetch becomes unexpected.
      run_cycle(mkv(1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0), "mid0");
      apply_reset();
      run_cycle(mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hE1, 1'b0, 1'b0, 1'b0), "mid1");
      run_cycle(mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), "mid2");
      run_cycle(mkv(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1), "mid3");
      run_cycle(mkv(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hE2, 1'b0, 1'b0, 1'b0), "mid4");
      chk("unexp held", {31'd0, unexp_rsp}, 32'd1);
      apply_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
